// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the truth-table sweeper and its controller/gate under test.
// slave = sweeper side, master = controller plus gate-under-test side.
interface truth_table_sweeper_if;
    logic       start;
    logic       out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] observed;
    logic [7:0] mismatch;

    modport slave (
        input  start, out,
        output in1, in2, in3, busy, done, pass, observed, mismatch
    );

    modport master (
        output start, out,
        input  in1, in2, in3, busy, done, pass, observed, mismatch
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through rows 000..111, samples its synchronized output per row, grades vs EXPECTED.
// Sweep takes 8*(SETTLE_CYCLES+1)+1 cycles from start to done; start is ignored while busy (no queuing).
module truth_table_sweeper #(
    parameter logic [7:0] EXPECTED      = 8'hB7,
    parameter int         SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);

    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_cfg_err
        $error("truth_table_sweeper: SETTLE_CYCLES must be within 3..255");
    end

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q,    state_d;
    logic [2:0] row_q,      row_d;
    logic [7:0] cnt_q,      cnt_d;
    logic       s1_q,       s1_d;
    logic       s2_q,       s2_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       pass_q,     pass_d;
    logic [7:0] observed_q, observed_d;
    logic [7:0] mismatch_q, mismatch_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= 3'd0;
            cnt_q      <= 8'd0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            observed_q <= 8'h00;
            mismatch_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            observed_q <= observed_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        s1_d       = bus.out;
        s2_d       = s1_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        observed_d = observed_q;
        mismatch_d = mismatch_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SETTLE;
                    row_d      = 3'd0;
                    cnt_d      = 8'd0;
                    observed_d = 8'h00;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    mismatch_d = 8'h00;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // Row i lands in bit 7-i so the code reads MSB-first like the gate's hex name.
                observed_d[3'd7 - row_q] = s2_q;
                if (row_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 3'd1;
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                mismatch_d = observed_q ^ EXPECTED;
                pass_d     = ((observed_q ^ EXPECTED) == 8'h00);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The row register doubles as the stimulus flops, so the gate inputs hold 111 after a sweep.
    assign bus.in1      = row_q[2];
    assign bus.in2      = row_q[1];
    assign bus.in3      = row_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.observed = observed_q;
    assign bus.mismatch = mismatch_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage placed directly upstream of a 3-input combinational gate circuit (e.g. the 0xB7 logic module). It drives the gate's `in1`/`in2`/`in3` through all eight input combinations in ascending order. For each row it waits a programmable settle time, then samples the gate's `out` through a 2-flop synchronizer. It assembles the observed 8-bit truth-table code and reports pass/fail against an expected code. It is used for on-chip characterization and regression of synthesized genetic-circuit netlists.

## Interface
- `EXPECTED`, 8'hB7, expected truth-table code; row `{in1,in2,in3}=i` maps to bit `7-i`.
- `SETTLE_CYCLES`, 4, cycles each input row is held before sampling; legal range 3..255.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  sweep request; accepted only in IDLE.
- `out`  input  1  gate output under test; asynchronous to `clk`; synchronized internally.
- `in1`, `in2`, `in3`  output  1 each  registered stimulus to the gate (MSB..LSB of row index).
- `busy`  output  1  high from the accepted `start` until `done`.
- `done`  output  1  one-cycle pulse when the sweep completes.
- `pass`  output  1  `mismatch == 0`; valid from `done` until the next accepted `start`.
- `observed`  output  8  captured truth-table code.
- `mismatch`  output  8  `observed ^ EXPECTED`.

## Operation
- Reset values: state IDLE, `{in1,in2,in3}=000`, `busy=0`, `done=0`, `pass=0`, `observed=8'h00`, `mismatch=8'h00`, row=0, settle counter=0, sync flops=0.
- Synchronizer: `out` → `s1` → `s2`; only `s2` is sampled.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE + `start`:
  - Go to SETTLE.
  - Set row=0, inputs=000, counter=0, `observed=0`, `busy=1`.
  - Set `pass=0` and `mismatch=0`.
- SETTLE:
  - Counter increments each cycle.
  - When counter==`SETTLE_CYCLES-1`, go to SAMPLE.
- SAMPLE:
  - Write `s2` into `observed[7-row]`.
  - If row==7, go to DONE.
  - Otherwise row+1, drive the new row on the inputs, clear the counter, and go to SETTLE.
- DONE:
  - `done=1` for exactly one cycle and `busy=0`.
  - Register `mismatch=observed^EXPECTED` and `pass=(mismatch==0)`; both appear together with `done`.
  - Go to IDLE.
- Inputs hold row 7 (111) after the sweep until the next `start` or reset.
- `start` outside IDLE (including DONE) is ignored, with no queuing.
- Row counter is 3 bits; completion is decided at row==7 and never wraps into row 0 mid-sweep.
- Counter is 8 bits; `SETTLE_CYCLES` outside 3..255 is a configuration error (elaboration assertion).
- Reset mid-sweep: immediate return to the reset values; a partial `observed` is discarded.
- `rst_n` is asserted asynchronously and deasserted synchronously at the block boundary (the external reset synchronizer's responsibility).

## Timing
- Let S=`SETTLE_CYCLES` and edge 0 = the rising edge that samples `start`=1 in IDLE.
- Row r inputs change at edge r·(S+1).
- Row r is captured at edge r·(S+1)+S+1.
- Gate combinational settle budget per row: S−1 full cycles before `s2` reflects it.
- Final capture at edge 8·(S+1).
- `done`/`pass`/`mismatch` are high/valid during the cycle after edge 8·(S+1)+1. The S=4 default gives `done` from edge 41 to edge 42.
- `busy` rises at edge 0 and falls at edge 8·(S+1)+1.
- `observed` bits update individually at each capture edge.
- Earliest next `start` accepted: edge 8·(S+1)+2.

## Test plan
- Ideal 0xB7 gate model, S=4, `start` pulse:
  - Inputs step 000..111 at edges 0, 5, …, 35.
  - `done` is seen at edge 41 with `observed=B7`, `mismatch=00`, `pass=1`.
- Gate stuck-at-0, S=4 → `observed=00`, `mismatch=B7`, `pass=0`.
- Gate with row 011 inverted (outputs 0 there) → `observed=A7`, `mismatch=10`, `pass=0`.
- `start` held high through an entire sweep plus a pulse during DONE:
  - Exactly one sweep runs and `done` pulses once.
  - A new sweep begins only when `start` is seen in IDLE.
- `rst_n` low at edge 17 of a sweep:
  - All outputs return to reset values immediately, asynchronously.
  - After release, a new `start` yields a full correct sweep.
- S=3 minimum with a gate model whose output lags the inputs by 0 ns:
  - Captures occur at edges 4, 8, …, 32 and `observed=B7`.
  - An extra 1-cycle output delay in the model still passes.
